// File: rtl/maxnet_iterator.sv
// maxnet_iterator: iterative winner-take-all (Maxnet) engine for four neurons.
// Loads four signed activations and clamps negatives to zero. It then applies
// mutual inhibition repeatedly. It stops when the external check stage reports
// a single survivor, when every activation has reached zero, or when the
// iteration cap is reached.
//
// Handshake: i_start is a level, not a valid/ready pair. It is sampled only in
// IDLE or DONE, and the sampling edge reloads the activations. It is ignored in
// CHECK and UPDATE. o_done is held high from entry into DONE until the edge
// that samples the next i_start. i_is_finished is a combinational function of
// o_active and must settle within the same CHECK cycle.
module maxnet_iterator #(
  parameter int WIDTH     = 16,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 32,
  localparam int CW       = $clog2(MAX_ITER + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_x0,
  input  logic [WIDTH-1:0] i_x1,
  input  logic [WIDTH-1:0] i_x2,
  input  logic [WIDTH-1:0] i_x3,
  output logic [3:0]       o_active,
  input  logic             i_is_finished,
  output logic             o_done,
  output logic             o_winner_valid,
  output logic [1:0]       o_winner,
  output logic [WIDTH-1:0] o_winner_value,
  output logic [CW-1:0]    o_iter_count,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHECK  = 2'd1,
    ST_UPDATE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a [4];
  logic [CW-1:0]    r_iter;
  logic             r_done;
  logic             r_winner_valid;
  logic [1:0]       r_winner;
  logic [WIDTH-1:0] r_winner_value;

  logic [3:0]       w_active;
  logic [WIDTH+1:0] w_sum;
  logic [WIDTH+1:0] w_t    [4];
  logic [WIDTH-1:0] w_next [4];
  logic [1:0]       w_win_idx;

  // ReLU on a two's complement input: negative values load as zero.
  function automatic logic [WIDTH-1:0] relu(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? '0 : x;
  endfunction

  // Nonzero flags, inhibition totals and the next activations for an UPDATE.
  // S - a_i is never negative because all activations are non-negative.
  always_comb begin
    w_sum = {2'b00, r_a[0]} + {2'b00, r_a[1]} + {2'b00, r_a[2]} + {2'b00, r_a[3]};
    for (int i = 0; i < 4; i++) begin
      w_active[i] = (r_a[i] != '0);
      w_t[i]      = (w_sum - {2'b00, r_a[i]}) >> EPS_SHIFT;
      // When a_i > t_i, t_i fits in WIDTH bits, so the subtraction cannot wrap.
      w_next[i]   = ({2'b00, r_a[i]} > w_t[i]) ? (r_a[i] - w_t[i][WIDTH-1:0]) : '0;
    end
  end

  // Index of the surviving neuron. When exactly one flag is set, this scan
  // selects that neuron.
  always_comb begin
    w_win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_active[i]) w_win_idx = 2'(i);
    end
  end

  // Control FSM with load, update and result registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      for (int i = 0; i < 4; i++) r_a[i] <= '0;
      r_iter         <= '0;
      r_done         <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner       <= 2'd0;
      r_winner_value <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            r_a[0]         <= relu(i_x0);
            r_a[1]         <= relu(i_x1);
            r_a[2]         <= relu(i_x2);
            r_a[3]         <= relu(i_x3);
            r_iter         <= '0;
            r_done         <= 1'b0;
            r_winner_valid <= 1'b0;
            r_winner       <= 2'd0;
            r_winner_value <= '0;
            r_state        <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (i_is_finished) begin
            r_done         <= 1'b1;
            r_winner_valid <= 1'b1;
            r_winner       <= w_win_idx;
            r_winner_value <= r_a[w_win_idx];
            r_state        <= ST_DONE;
          end else if (w_active == 4'b0000 || r_iter == CW'(MAX_ITER)) begin
            r_done         <= 1'b1;
            r_winner_valid <= 1'b0;
            r_winner       <= 2'd0;
            r_winner_value <= '0;
            r_state        <= ST_DONE;
          end else begin
            r_state <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          for (int i = 0; i < 4; i++) r_a[i] <= w_next[i];
          r_iter  <= r_iter + 1'b1;
          r_state <= ST_CHECK;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_active       = w_active;
  assign o_done         = r_done;
  assign o_winner_valid = r_winner_valid;
  assign o_winner       = r_winner;
  assign o_winner_value = r_winner_value;
  assign o_iter_count   = r_iter;
  assign o_state        = r_state;

endmodule

// File: tb/tb_maxnet_iterator.sv
// Bench for maxnet_iterator. It applies a table of directed vectors, then
// hand-written restart and reset sequences, then randomized runs that are
// compared against a behavioural Maxnet model.
module tb_maxnet_iterator;

  localparam int W    = 16;
  localparam int EPS  = 3;
  localparam int MAXI = 32;
  localparam int CW   = $clog2(MAXI + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  x0, x1, x2, x3;
  logic [3:0]    active;
  logic          is_finished;
  logic          done;
  logic          winner_valid;
  logic [1:0]    winner;
  logic [W-1:0]  winner_value;
  logic [CW-1:0] iter_count;
  logic [1:0]    state;

  int n_checks = 0;
  int n_fail   = 0;

  // Clock and reset block.
  always #5 clk = ~clk;

  // Termination-check stage: high when exactly one activation is nonzero.
  assign is_finished = ($countones(active) == 1);

  maxnet_iterator #(.WIDTH(W), .EPS_SHIFT(EPS), .MAX_ITER(MAXI)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_x0(x0), .i_x1(x1), .i_x2(x2), .i_x3(x3),
    .o_active(active), .i_is_finished(is_finished), .o_done(done),
    .o_winner_valid(winner_valid), .o_winner(winner),
    .o_winner_value(winner_value), .o_iter_count(iter_count), .o_state(state)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference Maxnet: ReLU, then inhibit with floor((sum of others) / 2^EPS)
  // until at most one neuron survives or the cap is reached.
  task automatic model(input int xs[4], output int fa[4], output int n);
    int s;
    int cnt;
    int na[4];
    for (int i = 0; i < 4; i++) fa[i] = (xs[i] < 0) ? 0 : xs[i];
    n = 0;
    while (1) begin
      cnt = 0;
      for (int i = 0; i < 4; i++) if (fa[i] != 0) cnt++;
      if (cnt <= 1 || n == MAXI) break;
      s = fa[0] + fa[1] + fa[2] + fa[3];
      for (int i = 0; i < 4; i++) begin
        na[i] = fa[i] - (s - fa[i]) / (1 << EPS);
        if (na[i] < 0) na[i] = 0;
      end
      fa = na;
      n++;
    end
  endtask

  // Drive start with the given inputs for one edge (E0). Then count the edges
  // until done is seen; the count is capped so the bench cannot hang.
  task automatic run(input int xs[4], output int edges);
    @(negedge clk);
    x0 = W'(xs[0]); x1 = W'(xs[1]); x2 = W'(xs[2]); x3 = W'(xs[3]);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (!done && edges < 200) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    chk("done_seen", done, 1);
  endtask

  typedef struct {
    int         x[4];
    logic       valid;
    logic [1:0] win;
    int         value;
    int         iters;
    logic [3:0] act;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int edges;
    int xs[4];
    int fa[4];
    int n;
    int cnt;
    int widx;
    logic [3:0] mact;

    rst = 1'b1; start = 1'b0; x0 = '0; x1 = '0; x2 = '0; x3 = '0;
    #12;
    // Reset state is checked while reset is still asserted.
    chk("rst_done", done, 0);
    chk("rst_valid", winner_valid, 0);
    chk("rst_winner", winner, 0);
    chk("rst_value", winner_value, 0);
    chk("rst_iter", iter_count, 0);
    chk("rst_active", active, 0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors: inputs, then valid, winner, value, iterations, active.
    vecs[0] = '{x: '{10, 0, 0, 0},   valid: 1, win: 0, value: 10,  iters: 0,  act: 4'b0001};
    vecs[1] = '{x: '{40, 20, 0, 0},  valid: 1, win: 0, value: 36,  iters: 5,  act: 4'b0001};
    vecs[2] = '{x: '{20, 20, 0, 0},  valid: 0, win: 0, value: 0,   iters: 32, act: 4'b0011};
    vecs[3] = '{x: '{-5, 0, -1, 0},  valid: 0, win: 0, value: 0,   iters: 0,  act: 4'b0000};
    vecs[4] = '{x: '{0, 0, 0, 100},  valid: 1, win: 3, value: 100, iters: 0,  act: 4'b1000};
    for (int v = 0; v < 5; v++) begin
      run(vecs[v].x, edges);
      chk($sformatf("v%0d_edges", v), edges, 1 + 2 * vecs[v].iters);
      chk($sformatf("v%0d_valid", v), winner_valid, vecs[v].valid);
      chk($sformatf("v%0d_winner", v), winner, vecs[v].win);
      chk($sformatf("v%0d_value", v), winner_value, vecs[v].value);
      chk($sformatf("v%0d_iter", v), iter_count, vecs[v].iters);
      chk($sformatf("v%0d_active", v), active, vecs[v].act);
    end

    // Restart from DONE (winner 3) with a new load: done must drop at the
    // sampling edge and rise again one cycle later.
    @(negedge clk);
    chk("hold_done", done, 1);
    x0 = 0; x1 = 50; x2 = 0; x3 = 0; start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("restart_done_low", done, 0);
    chk("restart_valid_low", winner_valid, 0);
    chk("restart_active", active, 4'b0010);
    @(posedge clk); @(negedge clk);
    chk("restart_done_high", done, 1);
    chk("restart_winner", winner, 1);
    chk("restart_value", winner_value, 50);

    // Asynchronous reset while UPDATE is in progress.
    x0 = 40; x1 = 20; x2 = 0; x3 = 0; start = 1'b1;
    @(posedge clk); @(negedge clk); start = 1'b0;   // after E0: CHECK
    @(posedge clk); @(negedge clk);                 // after E1: UPDATE
    @(posedge clk); @(negedge clk);                 // after E2: CHECK, (38,15)
    @(posedge clk); @(negedge clk);                 // after E3: UPDATE
    chk("mid_iter", iter_count, 1);
    chk("mid_active", active, 4'b0011);
    #2 rst = 1'b1;
    #1;
    chk("arst_done", done, 0);
    chk("arst_iter", iter_count, 0);
    chk("arst_active", active, 0);
    chk("arst_value", winner_value, 0);
    @(negedge clk); rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_active", active, 0);
    chk("idle_iter", iter_count, 0);

    // Randomized runs compared against the model.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 3))
          0: xs[i] = int'($signed(16'($urandom_range(0, 65535))));
          1: xs[i] = 0;
          default: xs[i] = int'($urandom_range(0, 300)) - 60;
        endcase
      end
      model(xs, fa, n);
      cnt = 0; widx = 0; mact = '0;
      for (int i = 0; i < 4; i++) begin
        if (fa[i] != 0) begin cnt++; widx = i; mact[i] = 1'b1; end
      end
      run(xs, edges);
      chk($sformatf("r%0d_edges", r), edges, 1 + 2 * n);
      chk($sformatf("r%0d_iter", r), iter_count, n);
      chk($sformatf("r%0d_active", r), active, mact);
      chk($sformatf("r%0d_valid", r), winner_valid, (cnt == 1) ? 1 : 0);
      chk($sformatf("r%0d_winner", r), winner, (cnt == 1) ? widx : 0);
      chk($sformatf("r%0d_value", r), winner_value, (cnt == 1) ? fa[widx] : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
